// File: rtl/layer_sequencer.sv
// Control sequencer for the multiply-add array: one streamed first layer followed
// by N_LAYERS-1 fed-back layers, driving buffer read enable and datapath mux select.
module layer_sequencer #(
    parameter int N_LAYERS        = 8,
    parameter int FIRST_LEN       = 32,
    parameter int OTHER_LEN       = 16,
    parameter int FMT_LAT         = 3,
    parameter int FIRST_HALF_RATE = 1,
    parameter int CNT_W           = 6,
    parameter int LAYER_W         = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               abort_i,
    input  logic               done_ack_i,
    output logic               read_en_o,
    output logic [1:0]         wire_connect_o,
    output logic               fmt_start_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [LAYER_W-1:0] layer_o
);

    // state     | meaning
    // IDLE      | waiting for start_i
    // FIRST_RUN | first layer streamed from the bus
    // FIRST_FMT | formatter drains the first layer
    // GETDAT    | one-cycle fetch of formatted data
    // OTHER_RUN | later layer with pass-down
    // OTHER_FMT | formatter drains a later layer
    // DONE      | run complete, waiting for done_ack_i
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FIRST_RUN = 3'd1,
        S_FIRST_FMT = 3'd2,
        S_GETDAT    = 3'd3,
        S_OTHER_RUN = 3'd4,
        S_OTHER_FMT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0]   FIRST_RUN_LAST  = CNT_W'(FIRST_LEN - 1);
    localparam logic [CNT_W-1:0]   FIRST_FMT_FIRST = CNT_W'(FIRST_LEN);
    localparam logic [CNT_W-1:0]   FIRST_FMT_LAST  = CNT_W'(FIRST_LEN + FMT_LAT - 1);
    localparam logic [CNT_W-1:0]   OTHER_RUN_LAST  = CNT_W'(OTHER_LEN - 2);
    localparam logic [CNT_W-1:0]   OTHER_FMT_LAST  = CNT_W'(FMT_LAT - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER      = LAYER_W'(N_LAYERS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        layer_d        = layer_q;
        read_en_o      = 1'b0;
        wire_connect_o = 2'd3;
        fmt_start_o    = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = S_FIRST_RUN;
                    cnt_d   = '0;
                    layer_d = '0;
                end
            end
            S_FIRST_RUN: begin
                wire_connect_o = 2'd0;
                read_en_o      = ((FIRST_HALF_RATE != 0) ? cnt_q[0] : 1'b1) & ~stall_i;
                if (!stall_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == FIRST_RUN_LAST)
                        state_d = S_FIRST_FMT;
                end
            end
            // The first-layer formatter window continues the run count.
            S_FIRST_FMT: begin
                fmt_start_o = (cnt_q == FIRST_FMT_FIRST);
                if (cnt_q == FIRST_FMT_LAST) begin
                    cnt_d = '0;
                    if (N_LAYERS == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GETDAT;
                        layer_d = LAYER_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GETDAT: begin
                wire_connect_o = 2'd1;
                read_en_o      = ~stall_i;
                if (!stall_i)
                    state_d = S_OTHER_RUN;
            end
            S_OTHER_RUN: begin
                wire_connect_o = 2'd2;
                read_en_o      = ~stall_i;
                if (!stall_i) begin
                    if (cnt_q == OTHER_RUN_LAST) begin
                        state_d = S_OTHER_FMT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_OTHER_FMT: begin
                fmt_start_o = (cnt_q == '0);
                if (cnt_q == OTHER_FMT_LAST) begin
                    cnt_d = '0;
                    if (layer_q == LAST_LAYER) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GETDAT;
                        layer_d = layer_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (done_ack_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    layer_d = '0;
                end
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
                cnt_d   = '0;
                layer_d = '0;
            end
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            layer_d = '0;
        end
    end

    assign layer_o = layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes expected run summaries and
// formatter layer indices; monitors pop and compare as the DUTs present them.
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0, stall_i = 1'b0, abort_i = 1'b0, done_ack_i = 1'b0;
    logic       read_en_o, fmt_start_o, busy_o, done_o;
    logic [1:0] wire_connect_o;
    logic [2:0] layer_o;

    logic       start1 = 1'b0, stall1 = 1'b0, abort1 = 1'b0, ack1 = 1'b0;
    logic       read_en1, fmt_start1, busy1, done1;
    logic [1:0] wire1;
    logic [2:0] layer1;

    layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i),
        .abort_i(abort_i), .done_ack_i(done_ack_i), .read_en_o(read_en_o),
        .wire_connect_o(wire_connect_o), .fmt_start_o(fmt_start_o),
        .busy_o(busy_o), .done_o(done_o), .layer_o(layer_o)
    );

    layer_sequencer #(.N_LAYERS(1), .FIRST_LEN(4), .FIRST_HALF_RATE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .stall_i(stall1),
        .abort_i(abort1), .done_ack_i(ack1), .read_en_o(read_en1),
        .wire_connect_o(wire1), .fmt_start_o(fmt_start1),
        .busy_o(busy1), .done_o(done1), .layer_o(layer1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int done_cyc; int odd; int even; int rd; int fmt; int tr;
    } run_t;
    typedef struct {
        int done_cyc; int rd; int win; int oth; int fmt;
    } run1_t;

    run_t  run_q[$];
    run1_t run1_q[$];
    int    fmt_q[$];

    function automatic bit legal_step(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'd3 && b == 2'd0) || (a == 2'd0 && b == 2'd3) ||
               (a == 2'd3 && b == 2'd1) || (a == 2'd1 && b == 2'd2) ||
               (a == 2'd2 && b == 2'd3);
    endfunction

    // monitor for the default-parameter instance
    int         run_start = -1, n_odd = 0, n_even = 0, n_rd = 0, n_fmt = 0, n_tr = 0, n_bad = 0;
    logic       prev_done = 1'b0;
    logic [1:0] prev_wire = 2'd3;
    run_t       er;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (!busy_o && !done_o) begin
                run_start = -1; n_odd = 0; n_even = 0; n_rd = 0;
                n_fmt = 0; n_tr = 0; n_bad = 0;
            end else begin
                if (busy_o && run_start < 0) run_start = cyc;
                if (read_en_o) begin
                    n_rd++;
                    if (wire_connect_o == 2'd0) begin
                        if ((cyc - run_start) % 2 == 1) n_odd++;
                        else n_even++;
                    end
                end
                if (fmt_start_o) begin
                    n_fmt++;
                    if (fmt_q.size() == 0) chk("fmt_unexpected", 1, 0);
                    else chk("fmt_layer", layer_o, fmt_q.pop_front());
                end
                if (wire_connect_o != prev_wire) begin
                    n_tr++;
                    if (!legal_step(prev_wire, wire_connect_o)) n_bad++;
                end
                if (done_o && !prev_done) begin
                    if (run_q.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        er = run_q.pop_front();
                        chk("done_cycle", cyc, er.done_cyc);
                        chk("first_reads_odd", n_odd, er.odd);
                        chk("first_reads_even", n_even, er.even);
                        chk("total_reads", n_rd, er.rd);
                        chk("fmt_pulses", n_fmt, er.fmt);
                        chk("wire_steps", n_tr, er.tr);
                        chk("wire_illegal_steps", n_bad, 0);
                        chk("done_wire", wire_connect_o, 3);
                    end
                end
            end
            prev_done = done_o;
            prev_wire = wire_connect_o;
        end
    end

    // monitor for the single-layer instance
    int    rs1 = -1, rd1 = 0, win1 = 0, oth1 = 0, fm1 = 0;
    logic  pd1 = 1'b0;
    run1_t er1;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (!busy1 && !done1) begin
                rs1 = -1; rd1 = 0; win1 = 0; oth1 = 0; fm1 = 0;
            end else begin
                if (busy1 && rs1 < 0) rs1 = cyc;
                if (read_en1) begin
                    rd1++;
                    if (cyc - rs1 < 4) win1++;
                end
                if (wire1 == 2'd1 || wire1 == 2'd2) oth1++;
                if (fmt_start1) fm1++;
                if (done1 && !pd1) begin
                    if (run1_q.size() == 0) begin
                        chk("done1_unexpected", 1, 0);
                    end else begin
                        er1 = run1_q.pop_front();
                        chk("done1_cycle", cyc, er1.done_cyc);
                        chk("reads1_total", rd1, er1.rd);
                        chk("reads1_consecutive", win1, er1.win);
                        chk("other_state_cycles1", oth1, er1.oth);
                        chk("fmt1_pulses", fm1, er1.fmt);
                        chk("layer1_at_done", layer1, 0);
                    end
                end
            end
            pd1 = done1;
        end
    end

    task automatic start_run(output int t);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        t = cyc - 1;
    endtask

    task automatic push_full(input int t, input int lat);
        run_q.push_back('{t + lat, 16, 0, 128, 8, 23});
        for (int l = 0; l < 8; l++) fmt_q.push_back(l);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_o !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        chk(name, done_o, 1);
    endtask

    task automatic ack_done();
        @(posedge clk); #1 done_ack_i = 1'b1;
        @(posedge clk); #1 done_ack_i = 1'b0;
        @(negedge clk);
        chk("ack_done_low", done_o, 0);
        chk("ack_busy_low", busy_o, 0);
        chk("ack_wire_idle", wire_connect_o, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read_en", read_en_o, 0);
        chk("rst_wire", wire_connect_o, 3);
        chk("rst_fmt_start", fmt_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_layer", layer_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // default run, no stall
        start_run(t);
        push_full(t, 169);
        wait_done("wait_done_default");
        ack_done();

        // single-layer instance: four back-to-back reads, no later-layer states
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        t = cyc - 1;
        run1_q.push_back('{t + 8, 4, 4, 0, 1});
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("wait_done1", done1, 1);
        @(posedge clk); #1 ack1 = 1'b1;
        @(posedge clk); #1 ack1 = 1'b0;
        @(negedge clk);
        chk("ack1_done_low", done1, 0);

        // five stalled cycles inside layer 3's run, plus a stall inside its formatter window
        start_run(t);
        push_full(t, 174);
        n = 0;
        while (!(layer_o == 3'd3 && wire_connect_o == 2'd2) && n < 300) begin @(negedge clk); n++; end
        chk("wait_layer3_run", wire_connect_o, 2);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_read_en", read_en_o, 0);
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        @(negedge clk);
        chk("read_resume", read_en_o, 1);
        n = 0;
        while (wire_connect_o == 2'd2 && n < 40) begin n++; @(negedge clk); end
        chk("run_cycles_after_stall", n, 11);
        chk("fmt_after_stall", fmt_start_o, 1);
        @(posedge clk); #1 stall_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 stall_i = 1'b0;
        wait_done("wait_done_stall");
        ack_done();

        // abort during the first formatter window
        fmt_q.push_back(0);
        start_run(t);
        n = 0;
        while (fmt_start_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("wait_first_fmt", fmt_start_o, 1);
        @(posedge clk); #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_o, 0);
        chk("abort_layer", layer_o, 0);
        chk("abort_wire", wire_connect_o, 3);
        chk("abort_done", done_o, 0);

        // abort together with start in IDLE stays in IDLE
        @(posedge clk); #1 begin abort_i = 1'b1; start_i = 1'b1; end
        @(posedge clk); #1 begin abort_i = 1'b0; start_i = 1'b0; end
        @(negedge clk);
        chk("abort_start_busy", busy_o, 0);
        chk("abort_start_wire", wire_connect_o, 3);
        @(negedge clk);
        chk("abort_start_busy_later", busy_o, 0);

        // reset in the middle of layer 2's run, then a fresh full run
        fmt_q.push_back(0);
        fmt_q.push_back(1);
        start_run(t);
        n = 0;
        while (!(layer_o == 3'd2 && wire_connect_o == 2'd2) && n < 300) begin @(negedge clk); n++; end
        chk("wait_layer2_run", wire_connect_o, 2);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_read_en", read_en_o, 0);
        chk("midrst_wire", wire_connect_o, 3);
        chk("midrst_fmt_start", fmt_start_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_layer", layer_o, 0);
        start_run(t);
        push_full(t, 169);
        wait_done("wait_done_after_reset");
        ack_done();

        repeat (3) @(negedge clk);
        chk("run_q_left", run_q.size(), 0);
        chk("run1_q_left", run1_q.size(), 0);
        chk("fmt_q_left", fmt_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised control sequencer for the multiply-add accelerator array. It steps the datapath through one first layer (streamed from the bus) and N_LAYERS-1 subsequent layers (fed back from the formatter), driving the read enable and the datapath mux select. Layer count, run lengths and formatter latency are parameters. The layer and cycle counters are internal. The block adds a start/done handshake, a stall input and an abort input. It sits between the host interface and the PE array mux/formatter.

## Interface
- N_LAYERS, 8: total layers including the first; must be at least 1.
- FIRST_LEN, 32: first-layer run cycles; must be at least 1.
- OTHER_LEN, 16: cycles per later layer, counting GETDAT; must be at least 2.
- FMT_LAT, 3: formatter cycles per layer; must be at least 1.
- FIRST_HALF_RATE, 1: if 1, first-layer reads occur on odd cycle counts only; if 0, a read occurs every cycle.
- CNT_W, 6: cycle counter width; must hold FIRST_LEN+FMT_LAT-1.
- LAYER_W, 3: layer index width; must satisfy 2^LAYER_W >= N_LAYERS.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  begin a run; sampled in IDLE only.
- stall_i  in  1  freeze in RUN and GETDAT states.
- abort_i  in  1  synchronous return to IDLE.
- done_ack_i  in  1  releases DONE.
- read_en_o  out  1  buffer read enable.
- wire_connect_o  out  2  mux select: 0 = v_bus/h_bus, 1 = formatted/h_bus, 2 = top/h_bus with pass-down, 3 = zero/zero.
- fmt_start_o  out  1  one-cycle pulse on the first formatter cycle of each layer.
- busy_o  out  1  high in every state except IDLE and DONE.
- done_o  out  1  high throughout DONE.
- layer_o  out  LAYER_W  index of the current layer; the first layer is 0.

## Operation
- States:
  - IDLE: read_en_o=0, wire=3. On start_i, go to FIRST_RUN with cnt=0 and layer=0.
  - FIRST_RUN: wire=0. read_en_o=cnt[0] if FIRST_HALF_RATE, else read_en_o=1. cnt increments each cycle. At cnt==FIRST_LEN-1, go to FIRST_FMT; cnt keeps counting.
  - FIRST_FMT: wire=3, read_en_o=0. Lasts FMT_LAT cycles. On the last cycle, go to DONE if N_LAYERS==1; otherwise go to GETDAT with layer=1 and cnt=0.
  - GETDAT: lasts 1 cycle; read_en_o=1, wire=1. Go to OTHER_RUN. cnt stays 0 in GETDAT and in the first OTHER_RUN cycle.
  - OTHER_RUN: read_en_o=1, wire=2. cnt runs 0..OTHER_LEN-2, then go to OTHER_FMT.
  - OTHER_FMT: wire=3, read_en_o=0. Lasts FMT_LAT cycles. On the last cycle, go to DONE if layer==N_LAYERS-1; otherwise increment layer and go to GETDAT with cnt=0.
  - DONE: done_o=1, wire=3. On done_ack_i, go to IDLE with layer=0.
- Stall:
  - In FIRST_RUN, GETDAT and OTHER_RUN, stall_i=1 holds state and cnt and forces read_en_o=0. wire_connect_o keeps its state value.
  - FMT states ignore stall_i; the formatter is autonomous.
  - The stall gating of read_en_o is the only combinational input-to-output path.
- Abort: abort_i=1 in any state sends the block to IDLE next cycle with cnt=0 and layer=0. It overrides start_i, stall_i and done_ack_i.
- fmt_start_o is 1 on the first cycle of each FIRST_FMT or OTHER_FMT visit only.
- start_i outside IDLE is ignored.
- Illegal state encodings go to IDLE next cycle.

## Timing
- Reset (rst_n=0 at clk edge): state=IDLE, cnt=0, layer=0. Outputs: read_en_o=0, wire_connect_o=3, fmt_start_o=0, busy_o=0, done_o=0, layer_o=0.
- All outputs are decoded from registered state, cnt and layer, except the stall gating of read_en_o.
- start_i is sampled at edge T. FIRST_RUN is visible from T+1.
- Without stalls, done_o rises at T+1+FIRST_LEN+FMT_LAT+(N_LAYERS-1)*(OTHER_LEN+FMT_LAT). With defaults this is T+169.
- Each stalled cycle in a RUN or GETDAT state adds exactly one cycle to that latency.
- done_ack_i is sampled at edge A. IDLE is visible at A+1, and start_i is accepted at A+1 at the earliest.
- start_i held high continuously restarts a run one cycle after each acknowledged DONE.

## Test plan
- Defaults, start pulse, no stall:
  - 16 read_en_o pulses occur at odd cnt in FIRST_RUN.
  - fmt_start_o pulses 8 times.
  - layer_o steps 0..7.
  - done_o rises 169 cycles after start; done_ack_i returns the block to IDLE next cycle.
- Stall for 5 cycles mid OTHER_RUN of layer 3:
  - read_en_o=0 and cnt is held during the stall.
  - done_o rises at 174.
  - Stall asserted inside OTHER_FMT has no effect.
- Abort in FIRST_FMT, and abort together with start_i in IDLE:
  - Next cycle the block is IDLE with busy_o=0, layer_o=0 and wire=3.
  - The simultaneous case stays in IDLE.
- N_LAYERS=1, FIRST_HALF_RATE=0, FIRST_LEN=4:
  - Four consecutive read_en_o cycles, then FMT.
  - No GETDAT or OTHER states are visited.
  - done_o at T+8.
- rst_n=0 mid OTHER_RUN: all outputs take their reset values next cycle, and a fresh start_i yields a full default sequence.
- Per-state wire_connect_o sequence is 0, 3, 1, 2, 3, and 3 in DONE.
